conv_core: RTL
==============

// Module: conv_core
// PURPOSE
//   Streaming 2-D convolution engine fed directly by conv_ram_ctrl. Loads a KxK
//   weight set, then accepts one raster-order DATA_SIZE x DATA_SIZE input plane
//   per pass. Emits the valid-region result, (DATA_SIZE-K+1)^2 words in row-major
//   order, back to the controller for write-out. Uses K-1 line buffers, a KxK
//   window and a 2-stage multiply/adder-tree pipeline; it never stalls.
// PARAMETERS
//   KERNEL_SIZE  5   kernel edge K (odd, >=3)
//   DATA_BW      8   input pixel width, unsigned
//   WEIGHT_BW    8   weight width, two's complement
//   ADDR_BW      5   weight index width (2^ADDR_BW >= K*K)
//   SUM_BW       16  output width, two's complement, saturated
//   DATA_SIZE    32  input plane edge W (square plane)
// PORTS
//   ACLK       in   1          clock, all logic on rising edge
//   ARESETn    in   1          asynchronous reset, active-low
//   i_w_valid  in   1          weight write strobe
//   i_addr     in   ADDR_BW    weight index, 0..K*K-1, row-major (0 = top-left)
//   i_w        in   WEIGHT_BW  weight value
//   i_valid    in   1          pixel strobe, one pixel per high cycle
//   i_x        in   DATA_BW    pixel value
//   o_valid    out  1          result strobe, one cycle per result
//   o_y        out  SUM_BW     convolution result
// BEHAVIOUR
//   Reset: o_valid=0, o_y=0, all weights=0, row/col counters=0, pipeline valid
//     tags=0. Line-buffer contents are don't-care. Reset mid-pass abandons the pass.
//   Weights: at an edge with i_w_valid=1 and i_addr<K*K, w[i_addr]<=i_w. Writes
//     with i_addr>=K*K are ignored. A write with i_addr==0 also clears row/col to
//     0 (pass resync). The controller loads weights only between passes.
//   Pixel position: col increments on each accepted pixel and wraps at W-1 to 0;
//     row then increments and wraps at W-1 to 0. After W*W pixels the counters are
//     back at 0 and the next pixel starts a new pass. i_valid gaps of any length
//     are allowed; state holds during them.
//   Window: the K-1 line buffers (depth W) and the KxK shift window advance only
//     on accepted pixels. A window is complete when the accepted pixel has
//     row>=K-1 and col>=K-1. Its output index is (row-K+1, col-K+1).
//     Windows that straddle a row wrap never produce output.
//   Arithmetic: p = {1'b0,x} * w, signed, DATA_BW+WEIGHT_BW+1 bits. The sum of K*K
//     products uses a width that holds the full sum without overflow.
//     Saturate to [-2^(SUM_BW-1), 2^(SUM_BW-1)-1].
//     y = sum over i,j of w[i*K+j] * win[i][j], where win[0][0] is the oldest pixel.
//   Pipeline (no backpressure): pixel accepted at edge E. Products and valid tag
//     are registered at E+1. Saturated sum is registered into o_y, with o_valid=1,
//     at E+2. o_valid falls at the next edge unless another result follows.
//     o_y holds its last value when o_valid=0. Throughput is 1 result/cycle.
//   Simultaneous i_w_valid and i_valid: the weight write happens at that edge, and
//     the pixel uses the old weights. If i_addr==0, the resync wins and the pixel
//     is taken as position (0,0).
//   Per pass: exactly (W-K+1)^2 o_valid pulses (784 at defaults). There is no
//     output for a partial pass.
// TESTING
//   1 All w=1, all x=1, 1024 back-to-back pixels -> 784 pulses, each o_y=25. First
//     o_valid 2 cycles after pixel 132 (row4,col4) is accepted.
//   2 Only w[12]=1, x=(r*32+c)&255 -> result (a,b) = pixel (a+2,b+2). Row-major
//     order checked against a reference model.
//   3 All w=127, x=255 -> o_y=32767. All w=-128, x=255 -> o_y=-32768 on every
//     output.
//   4 Test 2 with random 0-5 cycle i_valid gaps -> identical o_y sequence. o_valid
//     never high except 2 cycles after an accepted pixel.
//   5 ARESETn low after 500 pixels, weights reloaded, full pass -> no stale
//     outputs, 784 correct results. Write at i_addr=25 leaves weights unchanged.
//   6 Two passes back-to-back with a weight reload between -> 2x784 pulses.
//     Pass 2 uses only the new weights. No output for windows spanning the pass
//     boundary.

Source files
------------

// File: rtl/conv_core.sv
// Streaming KxK convolution over a raster-order WxW plane: line buffers feed a
// shift window, products and an adder tree with saturation follow, no stalls.
module conv_core #(
  parameter int KERNEL_SIZE = 5,
  parameter int DATA_BW     = 8,
  parameter int WEIGHT_BW   = 8,
  parameter int ADDR_BW     = 5,
  parameter int SUM_BW      = 16,
  parameter int DATA_SIZE   = 32
) (
  input  logic                 ACLK,
  input  logic                 ARESETn,
  input  logic                 i_w_valid,
  input  logic [ADDR_BW-1:0]   i_addr,
  input  logic [WEIGHT_BW-1:0] i_w,
  input  logic                 i_valid,
  input  logic [DATA_BW-1:0]   i_x,
  output logic                 o_valid,
  output logic [SUM_BW-1:0]    o_y
);

  localparam int K  = KERNEL_SIZE;
  localparam int W  = DATA_SIZE;
  localparam int KK = K * K;
  localparam int CB = $clog2(W);
  localparam int PB = DATA_BW + WEIGHT_BW + 1;
  localparam int FB = PB + $clog2(KK);
  localparam logic [CB-1:0] LAST = CB'(W - 1);
  localparam logic [CB-1:0] KM1  = CB'(K - 1);
  localparam logic signed [FB-1:0] MAXV = {{(FB-SUM_BW+1){1'b0}}, {(SUM_BW-1){1'b1}}};
  localparam logic signed [FB-1:0] MINV = {{(FB-SUM_BW+1){1'b1}}, {(SUM_BW-1){1'b0}}};

  logic [WEIGHT_BW-1:0]  w     [KK];
  logic [WEIGHT_BW-1:0]  w_d   [KK];
  logic [CB-1:0]         row, col;
  logic [CB-1:0]         pos_row, pos_col;
  logic                  resync;
  logic [DATA_BW-1:0]    lb    [K-1][W];
  logic [DATA_BW-1:0]    win   [K][K];
  logic [DATA_BW-1:0]    colv  [K];
  logic                  win_ok;
  logic signed [PB-1:0]  prod  [KK];
  logic                  prod_ok;
  logic signed [FB-1:0]  sum;
  logic [SUM_BW-1:0]     sat;

  // A write to weight 0 restarts the pass, and takes effect for a same-cycle pixel.
  assign resync  = i_w_valid && (i_addr == '0);
  assign pos_row = resync ? '0 : row;
  assign pos_col = resync ? '0 : col;

  function automatic logic signed [PB-1:0] mul(input logic [DATA_BW-1:0] x,
                                               input logic [WEIGHT_BW-1:0] wv);
    logic signed [PB-1:0] a, b;
    a = {{(PB-DATA_BW){1'b0}}, x};
    b = {{(PB-WEIGHT_BW){wv[WEIGHT_BW-1]}}, wv};
    return a * b;
  endfunction

  always_ff @(posedge ACLK or negedge ARESETn) begin
    if (!ARESETn) begin
      for (int k = 0; k < KK; k++) w[k] <= '0;
      row <= '0;
      col <= '0;
    end else begin
      for (int k = 0; k < KK; k++)
        if (i_w_valid && i_addr == ADDR_BW'(k)) w[k] <= i_w;
      if (i_valid) begin
        col <= (pos_col == LAST) ? '0 : pos_col + 1'b1;
        if (pos_col == LAST) row <= (pos_row == LAST) ? '0 : pos_row + 1'b1;
        else                 row <= pos_row;
      end else if (resync) begin
        row <= '0;
        col <= '0;
      end
    end
  end

  // Window row 0 is the oldest line; lb[0] holds the previous line.
  always_comb begin
    colv[K-1] = i_x;
    for (int i = 0; i < K-1; i++) colv[i] = lb[K-2-i][pos_col];
  end

  always_ff @(posedge ACLK) begin
    if (i_valid) begin
      lb[0][pos_col] <= i_x;
      for (int k = 1; k < K-1; k++) lb[k][pos_col] <= lb[k-1][pos_col];
      for (int i = 0; i < K; i++) begin
        for (int j = 0; j < K-1; j++) win[i][j] <= win[i][j+1];
        win[i][K-1] <= colv[i];
      end
    end
  end

  // w_d holds the weights as they were at the pixel's acceptance edge.
  always_ff @(posedge ACLK or negedge ARESETn) begin
    if (!ARESETn) begin
      for (int k = 0; k < KK; k++) begin
        w_d[k]  <= '0;
        prod[k] <= '0;
      end
      win_ok  <= 1'b0;
      prod_ok <= 1'b0;
      o_valid <= 1'b0;
      o_y     <= '0;
    end else begin
      for (int k = 0; k < KK; k++) w_d[k] <= w[k];
      win_ok <= i_valid && (pos_row >= KM1) && (pos_col >= KM1);
      for (int i = 0; i < K; i++)
        for (int j = 0; j < K; j++)
          prod[i*K+j] <= mul(win[i][j], w_d[i*K+j]);
      prod_ok <= win_ok;
      o_valid <= prod_ok;
      if (prod_ok) o_y <= sat;
    end
  end

  always_comb begin
    sum = '0;
    for (int k = 0; k < KK; k++)
      sum = sum + {{(FB-PB){prod[k][PB-1]}}, prod[k]};
    if (sum > MAXV)      sat = MAXV[SUM_BW-1:0];
    else if (sum < MINV) sat = MINV[SUM_BW-1:0];
    else                 sat = sum[SUM_BW-1:0];
  end

endmodule
